// File: rtl/bcd_counter_2d_pkg.sv
// Shared constants and helpers for the two-decade BCD counter.
package bcd_counter_2d_pkg;

    localparam int         BCD_W       = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] BCD_INVALID = 4'd0;

    // Nibbles that are not valid BCD are replaced rather than clamped.
    function automatic logic [BCD_W-1:0] bcd_sanitize(input logic [BCD_W-1:0] nib);
        return (nib > BCD_MAX) ? BCD_INVALID : nib;
    endfunction

endpackage

// File: rtl/bcd_counter_2d_bcd_digit.sv
// One BCD decade: holds a 0..9 value, steps up or down on a strobe,
// loads a sanitised preset, and flags a wrap on the stepping edge.
module bcd_digit
    import bcd_counter_2d_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_step,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [BCD_W-1:0] i_load_val,
    output logic [BCD_W-1:0] o_value,
    output logic             o_wrap
);

    logic [BCD_W-1:0] r_value;
    logic             w_at_edge;

    // The >= compare keeps the digit inside 0..9 even from a corrupted state.
    assign w_at_edge = i_up ? (r_value >= BCD_MAX) : (r_value == '0);
    assign o_wrap    = i_step && w_at_edge;
    assign o_value   = r_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (i_load) begin
            r_value <= bcd_sanitize(i_load_val);
        end else if (i_step) begin
            if (i_up)
                r_value <= w_at_edge ? '0 : r_value + BCD_W'(1);
            else
                r_value <= w_at_edge ? BCD_MAX : r_value - BCD_W'(1);
        end
    end

endmodule

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD counter (00..99) advanced by an enable-gated prescaler.
// Define BCD_DOWN_EN to let the up input select down counting.
module bcd_counter_2d
    import bcd_counter_2d_pkg::*;
#(
    parameter int PRESCALE = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [7:0]       load_val,
    input  logic             up,
    output logic [BCD_W-1:0] digit_ones,
    output logic [BCD_W-1:0] digit_tens,
    output logic             carry
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] r_presc;
    logic            r_carry;
    logic            w_tick;
    logic            w_up;
    logic            w_ones_wrap;
    logic            w_tens_wrap;

`ifdef BCD_DOWN_EN
    assign w_up = up;
`else
    // Up-only build: direction is fixed, the input is absorbed here.
    assign w_up = 1'b1 | up;
`endif

    assign w_tick = en && (r_presc == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (rst || load)
            r_presc <= '0;
        else if (en)
            r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
    end

    bcd_digit u_ones (
        .clk        (clk),
        .rst        (rst),
        .i_step     (w_tick),
        .i_up       (w_up),
        .i_load     (load),
        .i_load_val (load_val[3:0]),
        .o_value    (digit_ones),
        .o_wrap     (w_ones_wrap)
    );

    bcd_digit u_tens (
        .clk        (clk),
        .rst        (rst),
        .i_step     (w_ones_wrap),
        .i_up       (w_up),
        .i_load     (load),
        .i_load_val (load_val[7:4]),
        .o_value    (digit_tens),
        .o_wrap     (w_tens_wrap)
    );

    // Tens wrapping means the full 00<->99 rollover; a load suppresses it.
    always_ff @(posedge clk) begin
        if (rst)
            r_carry <= 1'b0;
        else
            r_carry <= w_tens_wrap && !load;
    end

    assign carry = r_carry;

endmodule

// File: tb/tb_bcd_counter_2d.sv
// Directed testbench for bcd_counter_2d: PRESCALE=4 and PRESCALE=1 instances.
module tb_bcd_counter_2d;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, load, up;
    logic [7:0] load_val;
    logic [3:0] ones, tens;
    logic       carry;

    logic       rst1, en1, load1, up1;
    logic [7:0] load_val1;
    logic [3:0] ones1, tens1;
    logic       carry1;

    int checks = 0;
    int errors = 0;

    bcd_counter_2d #(.PRESCALE(4)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .up(up),
        .digit_ones(ones), .digit_tens(tens), .carry(carry)
    );

    bcd_counter_2d #(.PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .load(load1), .load_val(load_val1), .up(up1),
        .digit_ones(ones1), .digit_tens(tens1), .carry(carry1)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 8'h55;
        cyc(1);
        checks++;
        if ({tens, ones} !== 8'h00) begin
            errors++; $display("FAIL reset_digits got %h want 00", {tens, ones});
        end
        checks++;
        if (carry !== 1'b0) begin
            errors++; $display("FAIL reset_carry got %b want 0", carry);
        end
        rst = 1'b0; en = 1'b0; load = 1'b0;
    endtask

    task automatic test_count_up;
        int n;
        logic [7:0] exp;
        rst = 1'b1; cyc(1); rst = 1'b0; en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            n = i / 4;
            exp = {4'(n / 10), 4'(n % 10)};
            checks++;
            if ({tens, ones} !== exp) begin
                errors++; $display("FAIL count_up cycle %0d got %h want %h", i, {tens, ones}, exp);
            end
            checks++;
            if (carry !== 1'b0) begin
                errors++; $display("FAIL count_up_carry cycle %0d got %b want 0", i, carry);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap;
        int carry_cnt;
        load_val = 8'h98; load = 1'b1; en = 1'b0;
        cyc(1);
        load = 1'b0;
        checks++;
        if ({tens, ones} !== 8'h98) begin
            errors++; $display("FAIL wrap_load got %h want 98", {tens, ones});
        end
        en = 1'b1; carry_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            if (carry === 1'b1) carry_cnt++;
            if (i == 4) begin
                checks++;
                if ({tens, ones} !== 8'h99) begin
                    errors++; $display("FAIL wrap_99 got %h want 99", {tens, ones});
                end
            end
        end
        checks++;
        if ({tens, ones} !== 8'h00 || carry !== 1'b1) begin
            errors++; $display("FAIL wrap_00 got %h carry %b want 00 carry 1", {tens, ones}, carry);
        end
        checks++;
        if (carry_cnt != 1) begin
            errors++; $display("FAIL wrap_carry_count got %0d want 1", carry_cnt);
        end
        cyc(1);
        checks++;
        if (carry !== 1'b0) begin
            errors++; $display("FAIL wrap_carry_drop got %b want 0", carry);
        end
        en = 1'b0;
    endtask

    task automatic test_invalid_load;
        logic [7:0] lv  [5] = '{8'hFA, 8'h3C, 8'hA7, 8'h9F, 8'h45};
        logic [7:0] exv [5] = '{8'h00, 8'h30, 8'h07, 8'h90, 8'h45};
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_val = lv[i]; load = 1'b1;
            cyc(1);
            load = 1'b0;
            checks++;
            if ({tens, ones} !== exv[i]) begin
                errors++; $display("FAIL invalid_load %h got %h want %h", lv[i], {tens, ones}, exv[i]);
            end
        end
    endtask

    task automatic test_load_priority;
        load_val = 8'h99; load = 1'b1; en = 1'b0;
        cyc(1);
        load = 1'b0; en = 1'b1;
        cyc(3);
        load_val = 8'h12; load = 1'b1;
        cyc(1);
        load = 1'b0;
        checks++;
        if ({tens, ones} !== 8'h12 || carry !== 1'b0) begin
            errors++; $display("FAIL load_priority got %h carry %b want 12 carry 0", {tens, ones}, carry);
        end
        cyc(3);
        checks++;
        if ({tens, ones} !== 8'h12) begin
            errors++; $display("FAIL load_presc_clear got %h want 12", {tens, ones});
        end
        cyc(1);
        checks++;
        if ({tens, ones} !== 8'h13) begin
            errors++; $display("FAIL load_next_step got %h want 13", {tens, ones});
        end
        en = 1'b0;
    endtask

    task automatic test_en_pause;
        rst = 1'b1; cyc(1); rst = 1'b0;
        en = 1'b1; cyc(2);
        en = 1'b0; cyc(10);
        checks++;
        if ({tens, ones} !== 8'h00) begin
            errors++; $display("FAIL pause_hold got %h want 00", {tens, ones});
        end
        en = 1'b1; cyc(1);
        checks++;
        if ({tens, ones} !== 8'h00) begin
            errors++; $display("FAIL pause_no_extra got %h want 00", {tens, ones});
        end
        cyc(1);
        checks++;
        if ({tens, ones} !== 8'h01) begin
            errors++; $display("FAIL pause_resume got %h want 01", {tens, ones});
        end
        cyc(3);
        checks++;
        if ({tens, ones} !== 8'h01) begin
            errors++; $display("FAIL pause_period_hold got %h want 01", {tens, ones});
        end
        cyc(1);
        checks++;
        if ({tens, ones} !== 8'h02) begin
            errors++; $display("FAIL pause_period_step got %h want 02", {tens, ones});
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid;
        rst = 1'b1; cyc(1); rst = 1'b0;
        en = 1'b1; cyc(6);
        checks++;
        if ({tens, ones} !== 8'h01) begin
            errors++; $display("FAIL midrst_pre got %h want 01", {tens, ones});
        end
        rst = 1'b1; cyc(1); rst = 1'b0;
        checks++;
        if ({tens, ones} !== 8'h00) begin
            errors++; $display("FAIL midrst_clear got %h want 00", {tens, ones});
        end
        cyc(3);
        checks++;
        if ({tens, ones} !== 8'h00) begin
            errors++; $display("FAIL midrst_full_period got %h want 00", {tens, ones});
        end
        cyc(1);
        checks++;
        if ({tens, ones} !== 8'h01) begin
            errors++; $display("FAIL midrst_restart got %h want 01", {tens, ones});
        end
        en = 1'b0;
    endtask

    task automatic test_direction;
        load_val = 8'h01; load = 1'b1; en = 1'b0; up = 1'b0;
        cyc(1);
        load = 1'b0; en = 1'b1;
        cyc(4);
`ifdef BCD_DOWN_EN
        checks++;
        if ({tens, ones} !== 8'h00 || carry !== 1'b0) begin
            errors++; $display("FAIL down_00 got %h carry %b want 00 carry 0", {tens, ones}, carry);
        end
        cyc(4);
        checks++;
        if ({tens, ones} !== 8'h99 || carry !== 1'b1) begin
            errors++; $display("FAIL down_99 got %h carry %b want 99 carry 1", {tens, ones}, carry);
        end
        cyc(1);
        checks++;
        if (carry !== 1'b0) begin
            errors++; $display("FAIL down_carry_drop got %b want 0", carry);
        end
        cyc(3);
        checks++;
        if ({tens, ones} !== 8'h98) begin
            errors++; $display("FAIL down_98 got %h want 98", {tens, ones});
        end
`else
        checks++;
        if ({tens, ones} !== 8'h02) begin
            errors++; $display("FAIL up_only got %h want 02", {tens, ones});
        end
        cyc(4);
        checks++;
        if ({tens, ones} !== 8'h03 || carry !== 1'b0) begin
            errors++; $display("FAIL up_only_2 got %h carry %b want 03 carry 0", {tens, ones}, carry);
        end
`endif
        en = 1'b0; up = 1'b1;
    endtask

    task automatic test_prescale1;
        rst1 = 1'b1; cyc(1); rst1 = 1'b0;
        en1 = 1'b1; load1 = 1'b1; load_val1 = 8'h42;
        cyc(1);
        load1 = 1'b0;
        checks++;
        if ({tens1, ones1} !== 8'h42 || carry1 !== 1'b0) begin
            errors++; $display("FAIL ps1_load_wins got %h carry %b want 42 carry 0", {tens1, ones1}, carry1);
        end
        cyc(1);
        checks++;
        if ({tens1, ones1} !== 8'h43) begin
            errors++; $display("FAIL ps1_step got %h want 43", {tens1, ones1});
        end
        cyc(1);
        checks++;
        if ({tens1, ones1} !== 8'h44) begin
            errors++; $display("FAIL ps1_step2 got %h want 44", {tens1, ones1});
        end
        load1 = 1'b1; load_val1 = 8'h99;
        cyc(1);
        load1 = 1'b0;
        cyc(1);
        checks++;
        if ({tens1, ones1} !== 8'h00 || carry1 !== 1'b1) begin
            errors++; $display("FAIL ps1_wrap got %h carry %b want 00 carry 1", {tens1, ones1}, carry1);
        end
        cyc(1);
        checks++;
        if ({tens1, ones1} !== 8'h01 || carry1 !== 1'b0) begin
            errors++; $display("FAIL ps1_after_wrap got %h carry %b want 01 carry 0", {tens1, ones1}, carry1);
        end
        en1 = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; load = 1'b0; load_val = 8'h00; up = 1'b1;
        rst1 = 1'b0; en1 = 1'b0; load1 = 1'b0; load_val1 = 8'h00; up1 = 1'b1;
        test_reset;
        test_count_up;
        test_wrap;
        test_invalid_load;
        test_load_priority;
        test_en_pause;
        test_reset_mid;
        test_direction;
        test_prescale1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_counter_2d.md
BCD_COUNTER_2D -- requirements
Module: bcd_counter_2d

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 50000000, meaning clock cycles per count step (legal range 1..2^26).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; one clock, reset synchronous and active-high.
REQ-004 The block SHALL have port en, input, 1, count enable (level).
REQ-005 The block SHALL have port load, input, 1, synchronous load strobe.
REQ-006 The block SHALL have port load_val, input, 8, preset value; [7:4] tens, [3:0] ones, BCD.
REQ-007 The block SHALL have port up, input, 1, direction (1=up, 0=down); ignored unless BCD_DOWN_EN is defined.
REQ-008 The block SHALL have port digit_ones, output, 4, registered BCD ones digit, the input to the BCD-to-7-segment decoder.
REQ-009 The block SHALL have port digit_tens, output, 4, registered BCD tens digit, the input to a second decoder instance.
REQ-010 The block SHALL have port carry, output, 1, one-cycle pulse on wrap (99->00 up, 00->99 down).

Function
REQ-011 A prescaler SHALL count 0..PRESCALE-1 while en=1, hold while en=0, and assert an internal tick in the cycle it equals PRESCALE-1, then wrap to 0.
REQ-012 PRESCALE=1 SHALL make tick equal to en, giving one step per enabled clock.
REQ-013 On tick, counting up: ones SHALL go to ones+1; at ones=9, ones SHALL go to 0 and tens to tens+1.
REQ-014 At 99 on an up tick the value SHALL become 00 and carry SHALL be 1 for exactly the following cycle; carry SHALL be 0 otherwise.
REQ-015 Digit outputs SHALL change in the cycle after the tick edge (one-clock latency); no combinational path from inputs to outputs.
REQ-016 load=1 SHALL take priority over tick: digits take load_val, prescaler clears to 0, carry SHALL be 0 that cycle, regardless of en.
REQ-017 Any load_val nibble above 9 SHALL be loaded as 0 for that digit only (e.g. 8'hA7 loads 07).
REQ-018 Digits SHALL never hold a value above 9 in any reachable state.

Reset
REQ-019 rst=1 SHALL set digit_ones=0, digit_tens=0, carry=0, prescaler=0 at the next clk edge.
REQ-020 rst SHALL take priority over load and tick; rst mid-count SHALL discard the partial prescale, and counting restarts a full PRESCALE after rst falls.

Configuration
REQ-021 With BCD_DOWN_EN defined, up=0 on tick SHALL decrement: ones 0->9 with tens-1, and 00->99 with a one-cycle carry pulse (borrow).
REQ-022 Without BCD_DOWN_EN, the up input SHALL be unused and the block SHALL count up only.
REQ-023 Changing up between ticks SHALL take effect at the next tick; prescaler phase SHALL be unaffected.

Structure
REQ-024 A shared package SHALL hold the BCD digit width (4), max digit value (9), and the invalid-nibble replacement value (0).
REQ-025 A sub-module bcd_digit (one decade: value, inc/dec strobe, load, wrap-out) SHALL be instantiated twice, ones wrap-out driving the tens strobe.
REQ-026 The prescaler width SHALL be derived from PRESCALE via clog2, minimum 1 bit.

Verification (PRESCALE=4 unless stated)
REQ-027 Reset, then en=1 for 40 cycles: digits SHALL step every 4 cycles, reaching 10 (tens=1, ones=0) after 40 cycles.
REQ-028 load_val=8'h98, load pulse, en=1 for 8 cycles: digits SHALL be 99 then 00, with carry high exactly one cycle at the 00 transition.
REQ-029 load_val=8'hFA: digits SHALL become 00; load_val=8'h3C SHALL give 30.
REQ-030 en toggled low for 10 cycles mid-prescale: count SHALL resume with no lost or extra step; rst asserted mid-prescale SHALL give 00 and a full 4-cycle restart.
REQ-031 BCD_DOWN_EN defined, up=0, load 8'h01, en=1: digits SHALL go 00 then 99 with carry pulse, then 98.
REQ-032 PRESCALE=1, load and tick in the same cycle: load value SHALL win; next enabled cycle SHALL step by one.
